// File: rtl/imem_pkg.sv
// imem_pkg: shared types and defaults for the instruction-memory load controller.
package imem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } imem_state_e;
    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = $clog2(IMEM_DEPTH);
endpackage

// File: rtl/imem_release_timer.sv
// imem_release_timer: loadable down-counter; done flags the final count so the owner can leave on that edge.
module imem_release_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign done = cnt_q == W'(1);
endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: owns the instruction-memory port, streams a program image in while holding the core
// in reset, then releases the core after a fixed delay and hands the port to its fetch path.
module imem_load_ctrl import imem_pkg::*; #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = IMEM_DEPTH,
    parameter int RELEASE_DLY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_last,
    output logic                     cpu_rst,
    input  logic                     cpu_fetch_req,
    input  logic [ADDR_W-1:0]        cpu_fetch_addr,
    output logic                     cpu_fetch_gnt,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [$clog2(DEPTH):0]   words_loaded,
    output logic                     load_err,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(RELEASE_DLY + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    imem_state_e state_q, state_d;
    logic [AW:0] words_q, words_d;
    logic        err_q, err_d;
    logic        accept, good, run, tmr_done;
    logic        unused_fetch_bits;

    assign run    = state_q == ST_RUN;
    assign accept = state_q == ST_LOAD && load_valid;
    // Good beats are word-aligned and fall inside the DEPTH-word window.
    assign good   = load_addr[1:0] == 2'b00 && (load_addr >> (AW + 2)) == '0;

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    words_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    words_d = (good && words_q != FULL) ? words_q + 1'b1 : words_q;
                    err_d   = err_q | ~good;
                    state_d = load_last ? ST_RELEASE : ST_LOAD;
                end
            end
            default: state_d = tmr_done ? ST_RUN : ST_RELEASE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    imem_release_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && load_last),
        .load_val (TW'(RELEASE_DLY)),
        .done     (tmr_done)
    );

    assign load_ready    = state_q == ST_LOAD;
    assign busy          = state_q == ST_LOAD || state_q == ST_RELEASE;
    assign cpu_rst       = !run;
    assign cpu_fetch_gnt = run && cpu_fetch_req;
    assign mem_we        = accept && good;
    assign mem_en        = mem_we || cpu_fetch_gnt;
    assign mem_addr      = mem_we ? load_addr[2 +: AW] : run ? cpu_fetch_addr[2 +: AW] : '0;
    assign mem_wdata     = mem_we ? load_data : '0;
    assign words_loaded  = words_q;
    assign load_err      = err_q;
    assign unused_fetch_bits = ^{cpu_fetch_addr[1:0], cpu_fetch_addr[ADDR_W-1:AW+2]};
endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Instruction-memory load controller between the bench/host loader and the `yourcpu` core. It owns the single instruction-memory port and holds the core in reset while a program image is streamed in over a valid/ready interface. After the last word, it releases the core following a fixed delay and hands the port to the core's fetch path. It replaces the ad-hoc `tb_addr`/`tb_inst` poking with a sequenced, checkable load.

## Interface
- `ADDR_W`, 32, byte-address width on loader and fetch sides
- `DATA_W`, 32, instruction word width
- `DEPTH`, 256, instruction memory depth in words (power of two)
- `RELEASE_DLY`, 4, cycles `cpu_rst` stays high after the last beat (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `load_start`  in  1  pulse; begins a load session
- `load_valid`  in  1  loader beat valid
- `load_ready`  out  1  controller accepts beat
- `load_addr`  in  ADDR_W  byte address of beat
- `load_data`  in  DATA_W  instruction word
- `load_last`  in  1  final beat of image
- `cpu_rst`  out  1  active-high reset to core
- `cpu_fetch_req`  in  1  core fetch request
- `cpu_fetch_addr`  in  ADDR_W  core fetch byte address
- `cpu_fetch_gnt`  out  1  fetch granted this cycle
- `mem_en`  out  1  memory port enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  $clog2(DEPTH)  word index
- `mem_wdata`  out  DATA_W  write data
- `words_loaded`  out  $clog2(DEPTH)+1  words written this session
- `load_err`  out  1  sticky bad-address flag
- `busy`  out  1  high in LOAD or RELEASE

## Operation
- FSM states: IDLE, LOAD, RELEASE, RUN.
- IDLE: `cpu_rst`=1. `load_start` moves to LOAD.
- LOAD: `load_ready`=1 and `cpu_rst`=1. A beat is accepted on `load_valid & load_ready`.
  - Accepted beat with good address: `mem_en`=`mem_we`=1, `mem_addr`=`load_addr[2 +: log2(DEPTH)]`, `mem_wdata`=`load_data`, all in the same cycle. `words_loaded` increments, saturating at DEPTH.
  - Bad address means `load_addr[1:0]`≠0 or `load_addr` ≥ 4·DEPTH. The beat is still accepted, but `mem_we`=0 and `load_err` is set.
  - Accepted beat with `load_last`=1 moves to RELEASE.
- RELEASE: `load_ready`=0 and `cpu_rst`=1. A counter runs RELEASE_DLY cycles, then the FSM moves to RUN.
- RUN: `cpu_rst`=0. `cpu_fetch_gnt`=`cpu_fetch_req`, `mem_en`=`cpu_fetch_req`, `mem_we`=0, `mem_addr`=`cpu_fetch_addr[2 +: log2(DEPTH)]`. Fetches are not range-checked. `load_start` moves to LOAD; `cpu_rst` rises on the next cycle.
- `load_start` clears `words_loaded` and `load_err` on entry to LOAD. It is ignored in LOAD and RELEASE.
- `cpu_fetch_gnt`=0 in every state other than RUN.
- `load_valid` outside LOAD is ignored and has no side effects.

## Timing
- Reset (`rst` high at a rising edge) sets state IDLE. Output values after reset: `cpu_rst`=1, `load_ready`=0, `cpu_fetch_gnt`=0, `mem_en`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `words_loaded`=0, `load_err`=0, `busy`=0.
- `rst` mid-LOAD or mid-RELEASE aborts to IDLE. Memory contents are not cleared.
- State changes are registered. `load_start` at edge N gives `load_ready`=1 from cycle N+1.
- The write occurs in the acceptance cycle; there is zero write latency.
- Last beat accepted at edge N: RELEASE spans cycles N+1..N+RELEASE_DLY, and `cpu_rst` falls at cycle N+RELEASE_DLY+1.
- Fetch-path outputs are combinational from `cpu_fetch_*` in RUN. Read data returns from the memory with that memory's latency; the controller does not touch read data.
- A beat with `load_last` and a bad address still terminates the session.

## Structure
- Shared package `imem_pkg`:
  - FSM enum `imem_state_e`
  - `IMEM_DEPTH`
  - localparam `IMEM_AW` = $clog2(DEPTH)
- One sub-module, `imem_release_timer`: a down-counter with load and done outputs, reused for core reset stretching.
- The memory itself stays outside this block.

## Test plan
- `rst` 2 cycles -> all outputs at reset values, `cpu_rst`=1, state IDLE.
- `load_start`, then 4 beats at addresses 0x0/0x4/0x8/0xC with data 0x00500093.., last on the 4th beat -> `mem_we` pulses at word indices 0..3, `words_loaded`=4, `cpu_rst` falls exactly 4 cycles after the last beat, then fetches at 0x8 give `mem_addr`=2 and `cpu_fetch_gnt`=1.
- Beat at 0x6 (misaligned), then beat at 0x400 with DEPTH=256 -> no writes, `load_err`=1 and sticky, `words_loaded`=0. A later `load_start` clears it.
- `load_valid` toggling with gaps and `load_start` re-pulsed mid-LOAD -> no extra writes, `words_loaded` counts only accepted good beats.
- `load_start` in RUN -> `cpu_rst`=1 and `cpu_fetch_gnt`=0 next cycle while `cpu_fetch_req`=1. The new image loads and `cpu_rst` is released again.
- `rst` asserted 2 cycles into RELEASE -> IDLE, `cpu_rst` stays 1, and no RUN entry without a new load.
